// File: rtl/alpha_pkg.sv
// Shared Alpha decode definitions: instruction classes, opcode constants, issue states.
package alpha_pkg;

    typedef enum logic [3:0] {
        OPR    = 4'd0,
        MEM_LD = 4'd1,
        MEM_ST = 4'd2,
        BR     = 4'd3,
        CBR    = 4'd4,
        JMP    = 4'd5,
        PAL    = 4'd6,
        REI    = 4'd7,
        MISC   = 4'd8,
        ILL    = 4'd9
    } instn_class_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_WAIT_RDR = 2'd2
    } idu_state_e;

    localparam logic [4:0] R_ZERO = 5'd31;

    localparam logic [5:0] OP_PAL  = 6'h00;
    localparam logic [5:0] OP_LDA  = 6'h08;
    localparam logic [5:0] OP_INTA = 6'h10;
    localparam logic [5:0] OP_INTM = 6'h13;
    localparam logic [5:0] OP_MISC = 6'h18;
    localparam logic [5:0] OP_JMP  = 6'h1A;
    localparam logic [5:0] OP_REI  = 6'h1E;
    localparam logic [5:0] OP_MEMX = 6'h2F;
    localparam logic [5:0] OP_BR   = 6'h30;
    localparam logic [5:0] OP_BSR  = 6'h34;
    localparam logic [5:0] OP_CBR0 = 6'h38;
    localparam logic [5:0] OP_CBR7 = 6'h3F;

    // Memory-format opcodes that read ra instead of writing it.
    function automatic logic is_store(input logic [5:0] op);
        return op inside {6'h0D, 6'h0E, 6'h0F, [6'h24:6'h27], [6'h2C:6'h2F]};
    endfunction

endpackage

// File: rtl/idu_decode.sv
// Combinational Alpha opcode decoder: class, source/destination registers, literal and
// sign-extended displacement. IDU_ILLEGAL_TRAP_EN selects whether unknown opcodes decode as ILL.
module idu_decode
    import alpha_pkg::*;
(
    input  logic [31:0]  opcode,
    output instn_class_e cls,
    output logic [4:0]   ra,
    output logic [4:0]   rb,
    output logic [4:0]   rd,
    output logic         use_lit,
    output logic [63:0]  imm
);

    logic [5:0] op;
    logic [4:0] f_ra;
    logic [4:0] f_rb;
    logic [4:0] f_rc;

    assign op   = opcode[31:26];
    assign f_ra = opcode[25:21];
    assign f_rb = opcode[20:16];
    assign f_rc = opcode[4:0];

    always_comb begin
`ifdef IDU_ILLEGAL_TRAP_EN
        cls = ILL;
`else
        cls = OPR;
`endif
        ra      = R_ZERO;
        rb      = R_ZERO;
        rd      = R_ZERO;
        use_lit = 1'b0;
        imm     = '0;

        if (op inside {[OP_INTA:OP_INTM]}) begin
            cls     = OPR;
            ra      = f_ra;
            rd      = f_rc;
            use_lit = opcode[12];
            // The operate literal is an unsigned 8-bit quantity.
            if (opcode[12]) imm = {56'd0, opcode[20:13]};
            else            rb  = f_rb;
        end else if (op inside {[OP_LDA:6'h0F], [6'h20:OP_MEMX]}) begin
            rb  = f_rb;
            imm = {{48{opcode[15]}}, opcode[15:0]};
            if (is_store(op)) begin
                cls = MEM_ST;
                ra  = f_ra;
            end else begin
                cls = MEM_LD;
                rd  = f_ra;
            end
        end else if (op == OP_BR || op == OP_BSR) begin
            cls = BR;
            rd  = f_ra;
            imm = {{41{opcode[20]}}, opcode[20:0], 2'b00};
        end else if (op inside {[OP_CBR0:OP_CBR7]}) begin
            cls = CBR;
            ra  = f_ra;
            imm = {{41{opcode[20]}}, opcode[20:0], 2'b00};
        end else if (op == OP_JMP) begin
            cls = JMP;
            rb  = f_rb;
            rd  = f_ra;
        end else if (op == OP_PAL) begin
            cls = PAL;
        end else if (op == OP_REI) begin
            cls = REI;
        end else if (op == OP_MISC) begin
            cls = MISC;
        end
    end

endmodule

// File: rtl/idu.sv
// Alpha decode/issue stage: scoreboard hazard check, serialization FSM and ID->EX register.
// Define IDU_ILLEGAL_TRAP_EN to issue illegal opcodes as class ILL through the drain path.
module idu
    import alpha_pkg::*;
#(
    parameter int NUM_GPR = 32,
    parameter int PC_W    = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instn_vld_id,
    input  logic            instn_pr_taken_id,
    input  logic [31:0]     instn_opcode_id,
    input  logic [PC_W-1:0] instn_pc_id,
    output logic            instn_accepted_id,
    input  logic            redir_vld,
    input  logic            wb_vld,
    input  logic [4:0]      wb_reg,
    output logic            ex_vld,
    input  logic            ex_ready,
    output logic [PC_W-1:0] ex_pc,
    output logic [31:0]     ex_opcode,
    output logic [3:0]      ex_class,
    output logic [4:0]      ex_ra,
    output logic [4:0]      ex_rb,
    output logic [4:0]      ex_rd,
    output logic            ex_use_lit,
    output logic [63:0]     ex_imm,
    output logic            ex_pr_taken
);

    instn_class_e       dec_cls;
    logic [4:0]         dec_ra;
    logic [4:0]         dec_rb;
    logic [4:0]         dec_rd;
    logic               dec_use_lit;
    logic [63:0]        dec_imm;

    idu_state_e         state;
    logic [NUM_GPR-1:0] sb;
    logic [NUM_GPR-1:0] sb_set;
    logic [NUM_GPR-1:0] sb_clr;
    logic [NUM_GPR-1:0] sb_live;
    logic               hazard;
    logic               serial;
    logic               allow;
    logic               accept;

    idu_decode u_decode (
        .opcode  (instn_opcode_id),
        .cls     (dec_cls),
        .ra      (dec_ra),
        .rb      (dec_rb),
        .rd      (dec_rd),
        .use_lit (dec_use_lit),
        .imm     (dec_imm)
    );

    function automatic logic reg_busy(input logic [4:0] r, input logic [NUM_GPR-1:0] live,
                                      input logic hit_vld, input logic [4:0] hit_rd);
        return (r != R_ZERO) && (live[r] || (hit_vld && hit_rd == r));
    endfunction

    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (ex_vld && ex_ready && ex_rd != R_ZERO) sb_set[ex_rd] = 1'b1;
        if (wb_vld) sb_clr[wb_reg] = 1'b1;
    end

    // Write-through register file: a register retiring this cycle is already readable.
    assign sb_live = sb & ~sb_clr;

    assign hazard = reg_busy(dec_ra, sb_live, ex_vld, ex_rd)
                  | reg_busy(dec_rb, sb_live, ex_vld, ex_rd)
                  | reg_busy(dec_rd, sb_live, ex_vld, ex_rd);

`ifdef IDU_ILLEGAL_TRAP_EN
    assign serial = dec_cls inside {PAL, REI, MISC, ILL};
`else
    assign serial = dec_cls inside {PAL, REI, MISC};
`endif

    always_comb begin
        allow = 1'b0;
        case (state)
            ST_RUN:      allow = ~serial;
            ST_DRAIN:    allow = (sb == '0) && !ex_vld;
            ST_WAIT_RDR: allow = 1'b0;
            default:     allow = 1'b0;
        endcase
    end

    assign accept = !reset && instn_vld_id && !redir_vld && !hazard
                  && (!ex_vld || ex_ready) && allow;
    assign instn_accepted_id = accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else if (redir_vld) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (instn_vld_id && serial)       state <= ST_DRAIN;
                    else if (accept && dec_cls == JMP) state <= ST_WAIT_RDR;
                end
                ST_DRAIN: begin
                    if (accept) state <= (dec_cls == MISC) ? ST_RUN : ST_WAIT_RDR;
                end
                ST_WAIT_RDR: state <= ST_WAIT_RDR;
                default:     state <= ST_RUN;
            endcase
        end
    end

    // Set wins over a same-cycle writeback clear of the same register.
    always_ff @(posedge clk) begin
        if (reset) sb <= '0;
        else       sb <= sb_live | sb_set;
    end

    // ID->EX register
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_vld      <= 1'b0;
            ex_pc       <= '0;
            ex_opcode   <= '0;
            ex_class    <= '0;
            ex_ra       <= '0;
            ex_rb       <= '0;
            ex_rd       <= '0;
            ex_use_lit  <= 1'b0;
            ex_imm      <= '0;
            ex_pr_taken <= 1'b0;
        end else if (redir_vld) begin
            ex_vld <= 1'b0;
        end else if (accept) begin
            ex_vld      <= 1'b1;
            ex_pc       <= instn_pc_id;
            ex_opcode   <= instn_opcode_id;
            ex_class    <= dec_cls;
            ex_ra       <= dec_ra;
            ex_rb       <= dec_rb;
            ex_rd       <= dec_rd;
            ex_use_lit  <= dec_use_lit;
            ex_imm      <= dec_imm;
            ex_pr_taken <= instn_pr_taken_id;
        end else if (ex_ready) begin
            ex_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_idu.sv
// Directed bench for idu: expected ID->EX records queued at acceptance, checked at issue.
module tb_idu;
    import alpha_pkg::*;

    localparam int PC_W = 64;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] op;
        logic [3:0]  cls;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  rd;
        logic        lit;
        logic [63:0] imm;
        logic        tk;
    } rec_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            instn_vld_id;
    logic            instn_pr_taken_id;
    logic [31:0]     instn_opcode_id;
    logic [PC_W-1:0] instn_pc_id;
    logic            instn_accepted_id;
    logic            redir_vld;
    logic            wb_vld;
    logic [4:0]      wb_reg;
    logic            ex_vld;
    logic            ex_ready;
    logic [PC_W-1:0] ex_pc;
    logic [31:0]     ex_opcode;
    logic [3:0]      ex_class;
    logic [4:0]      ex_ra;
    logic [4:0]      ex_rb;
    logic [4:0]      ex_rd;
    logic            ex_use_lit;
    logic [63:0]     ex_imm;
    logic            ex_pr_taken;

    rec_t exp_q[$];
    rec_t cur_exp;
    rec_t ex_now;
    rec_t ex_s;
    rec_t e;
    rec_t ldq_e;
    logic acc_s;
    logic exv_s;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    idu #(.NUM_GPR(32), .PC_W(PC_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .instn_vld_id      (instn_vld_id),
        .instn_pr_taken_id (instn_pr_taken_id),
        .instn_opcode_id   (instn_opcode_id),
        .instn_pc_id       (instn_pc_id),
        .instn_accepted_id (instn_accepted_id),
        .redir_vld         (redir_vld),
        .wb_vld            (wb_vld),
        .wb_reg            (wb_reg),
        .ex_vld            (ex_vld),
        .ex_ready          (ex_ready),
        .ex_pc             (ex_pc),
        .ex_opcode         (ex_opcode),
        .ex_class          (ex_class),
        .ex_ra             (ex_ra),
        .ex_rb             (ex_rb),
        .ex_rd             (ex_rd),
        .ex_use_lit        (ex_use_lit),
        .ex_imm            (ex_imm),
        .ex_pr_taken       (ex_pr_taken)
    );

    assign ex_now = {ex_pc, ex_opcode, ex_class, ex_ra, ex_rb, ex_rd, ex_use_lit, ex_imm, ex_pr_taken};

    function automatic logic [31:0] enc_opr(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rc);
        return {6'h10, ra, rb, 3'b000, 1'b0, 7'h20, rc};
    endfunction

    function automatic logic [31:0] enc_lit(input logic [4:0] ra, input logic [7:0] lit, input logic [4:0] rc);
        return {6'h10, ra, lit, 1'b1, 7'h20, rc};
    endfunction

    function automatic logic [31:0] enc_mem(input logic [5:0] op, input logic [4:0] ra, input logic [4:0] rb,
                                            input logic [15:0] disp);
        return {op, ra, rb, disp};
    endfunction

    function automatic logic [31:0] enc_br(input logic [5:0] op, input logic [4:0] ra, input logic [20:0] disp);
        return {op, ra, disp};
    endfunction

    function automatic logic [31:0] enc_jmp(input logic [4:0] ra, input logic [4:0] rb);
        return {6'h1A, ra, rb, 2'b00, 14'h0};
    endfunction

    function automatic rec_t mk(input logic [63:0] pc, input logic [31:0] op, input logic [3:0] cls,
                                input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                                input logic lit, input logic [63:0] imm, input logic tk);
        return {pc, op, cls, ra, rb, rd, lit, imm, tk};
    endfunction

    task automatic chk_bit(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic chk_rec(input string tag, input rec_t obs, input rec_t expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed pc=%h op=%h cls=%0d ra=%0d rb=%0d rd=%0d lit=%b imm=%h tk=%b expected pc=%h op=%h cls=%0d ra=%0d rb=%0d rd=%0d lit=%b imm=%h tk=%b",
                   tag, obs.pc, obs.op, obs.cls, obs.ra, obs.rb, obs.rd, obs.lit, obs.imm, obs.tk,
                   expv.pc, expv.op, expv.cls, expv.ra, expv.rb, expv.rd, expv.lit, expv.imm, expv.tk);
        end
    endtask

    task automatic head(input logic [31:0] op, input logic [63:0] pc, input logic tk, input rec_t ex);
        instn_vld_id      = 1'b1;
        instn_opcode_id   = op;
        instn_pc_id       = pc;
        instn_pr_taken_id = tk;
        cur_exp           = ex;
    endtask

    task automatic idle();
        instn_vld_id = 1'b0;
    endtask

    // One clock: sample just before the edge, retire/enqueue scoreboard entries, advance.
    task automatic cycle();
        #1;
        acc_s = instn_accepted_id;
        exv_s = ex_vld;
        ex_s  = ex_now;
        if (redir_vld) begin
            if (ex_vld && exp_q.size() != 0) void'(exp_q.pop_front());
        end else if (ex_vld && ex_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL ex_unexpected observed issue pc=%h expected no issue", ex_pc);
            end
            if (exp_q.size() != 0) chk_rec("ex_issue", ex_s, exp_q.pop_front());
        end
        if (!reset && instn_vld_id && instn_accepted_id) exp_q.push_back(cur_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic wb_clear(input logic [4:0] r);
        wb_vld = 1'b1;
        wb_reg = r;
        idle();
        cycle();
        wb_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; instn_vld_id = 1'b0; instn_pr_taken_id = 1'b0; instn_opcode_id = '0;
        instn_pc_id = '0; redir_vld = 1'b0; wb_vld = 1'b0; wb_reg = '0; ex_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset
        e = mk(64'h100, enc_opr(5'd1, 5'd2, 5'd3), OPR, 5'd1, 5'd2, 5'd3, 1'b0, 64'h0, 1'b0);
        head(enc_opr(5'd1, 5'd2, 5'd3), 64'h100, 1'b0, e);
        cycle(); chk_bit("reset_acc", acc_s, 1'b0);
        cycle(); chk_bit("reset_acc2", acc_s, 1'b0);
        chk_bit("reset_ex_vld", ex_vld, 1'b0);
        chk_rec("reset_ex_fields", ex_now, '0);
        reset = 1'b0;

        // Back-to-back RAW on r3
        cycle(); chk_bit("t1_first_acc", acc_s, 1'b1);
        e = mk(64'h104, enc_opr(5'd3, 5'd4, 5'd5), OPR, 5'd3, 5'd4, 5'd5, 1'b0, 64'h0, 1'b0);
        head(enc_opr(5'd3, 5'd4, 5'd5), 64'h104, 1'b0, e);
        cycle(); chk_bit("t1_ex_stall", acc_s, 1'b0);
        cycle(); chk_bit("t1_sb_stall", acc_s, 1'b0);
        wb_vld = 1'b1; wb_reg = 5'd3;
        cycle(); chk_bit("t1_wb_accept", acc_s, 1'b1);
        wb_vld = 1'b0; idle(); cycle();

        // LDQ held by ex_ready=0
        wb_vld = 1'b1; wb_reg = 5'd5; ex_ready = 1'b0;
        ldq_e = mk(64'h200, enc_mem(6'h29, 5'd7, 5'd2, 16'h0010), MEM_LD, 5'd31, 5'd2, 5'd7, 1'b0, 64'h10, 1'b0);
        head(enc_mem(6'h29, 5'd7, 5'd2, 16'h0010), 64'h200, 1'b0, ldq_e);
        cycle(); chk_bit("t2_ldq_acc", acc_s, 1'b1);
        wb_vld = 1'b0;
        e = mk(64'h204, enc_opr(5'd1, 5'd2, 5'd4), OPR, 5'd1, 5'd2, 5'd4, 1'b0, 64'h0, 1'b0);
        head(enc_opr(5'd1, 5'd2, 5'd4), 64'h204, 1'b0, e);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk_bit("t2_hold_acc", acc_s, 1'b0);
            chk_bit("t2_hold_vld", exv_s, 1'b1);
            chk_rec("t2_hold_ex", ex_s, ldq_e);
        end
        ex_ready = 1'b1;
        cycle(); chk_bit("t2_release_acc", acc_s, 1'b1);
        idle(); cycle();
        wb_clear(5'd7); wb_clear(5'd4);

        // Set beats same-cycle clear on r9
        e = mk(64'h300, enc_mem(6'h08, 5'd9, 5'd31, 16'hFFF0), MEM_LD, 5'd31, 5'd31, 5'd9, 1'b0,
               64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
        head(enc_mem(6'h08, 5'd9, 5'd31, 16'hFFF0), 64'h300, 1'b0, e);
        cycle(); chk_bit("t3_lda_acc", acc_s, 1'b1);
        idle(); wb_vld = 1'b1; wb_reg = 5'd9;
        cycle();
        wb_vld = 1'b0;
        e = mk(64'h304, enc_opr(5'd9, 5'd1, 5'd2), OPR, 5'd9, 5'd1, 5'd2, 1'b0, 64'h0, 1'b0);
        head(enc_opr(5'd9, 5'd1, 5'd2), 64'h304, 1'b0, e);
        cycle(); chk_bit("t3_set_wins", acc_s, 1'b0);
        cycle(); chk_bit("t3_still_busy", acc_s, 1'b0);
        wb_vld = 1'b1; wb_reg = 5'd9;
        cycle(); chk_bit("t3_wb_accept", acc_s, 1'b1);
        wb_vld = 1'b0; idle(); cycle();
        wb_clear(5'd2);

        // JMP waits for redirect
        e = mk(64'h1000, enc_jmp(5'd26, 5'd27), JMP, 5'd31, 5'd27, 5'd26, 1'b0, 64'h0, 1'b0);
        head(enc_jmp(5'd26, 5'd27), 64'h1000, 1'b0, e);
        cycle(); chk_bit("t4_jmp_acc", acc_s, 1'b1);
        e = mk(64'h1100, enc_opr(5'd1, 5'd1, 5'd1), OPR, 5'd1, 5'd1, 5'd1, 1'b0, 64'h0, 1'b0);
        head(enc_opr(5'd1, 5'd1, 5'd1), 64'h1100, 1'b0, e);
        cycle(); chk_bit("t4_wait_acc", acc_s, 1'b0);
        cycle(); chk_bit("t4_wait_acc2", acc_s, 1'b0);
        redir_vld = 1'b1;
        cycle(); chk_bit("t4_redir_acc", acc_s, 1'b0);
        redir_vld = 1'b0;
        cycle(); chk_bit("t4_after_redir_acc", acc_s, 1'b1);
        idle(); cycle();
        wb_clear(5'd26); wb_clear(5'd1);

        // CALL_PAL drains r4/r5 then waits for redirect
        e = mk(64'h400, enc_mem(6'h29, 5'd4, 5'd3, 16'h0000), MEM_LD, 5'd31, 5'd3, 5'd4, 1'b0, 64'h0, 1'b0);
        head(enc_mem(6'h29, 5'd4, 5'd3, 16'h0000), 64'h400, 1'b0, e);
        cycle(); chk_bit("t5_ld4_acc", acc_s, 1'b1);
        e = mk(64'h404, enc_mem(6'h29, 5'd5, 5'd3, 16'h0008), MEM_LD, 5'd31, 5'd3, 5'd5, 1'b0, 64'h8, 1'b0);
        head(enc_mem(6'h29, 5'd5, 5'd3, 16'h0008), 64'h404, 1'b0, e);
        cycle(); chk_bit("t5_ld5_acc", acc_s, 1'b1);
        e = mk(64'h408, 32'h0000_0083, PAL, 5'd31, 5'd31, 5'd31, 1'b0, 64'h0, 1'b0);
        head(32'h0000_0083, 64'h408, 1'b0, e);
        cycle(); chk_bit("t5_pal_enter_drain", acc_s, 1'b0);
        cycle(); chk_bit("t5_drain_busy", acc_s, 1'b0);
        wb_vld = 1'b1; wb_reg = 5'd4;
        cycle(); chk_bit("t5_drain_one_left", acc_s, 1'b0);
        wb_reg = 5'd5; idle();
        cycle();
        wb_vld = 1'b0;
        head(32'h0000_0083, 64'h408, 1'b0, e);
        cycle(); chk_bit("t5_drain_issue", acc_s, 1'b1);
        e = mk(64'h500, enc_opr(5'd1, 5'd2, 5'd10), OPR, 5'd1, 5'd2, 5'd10, 1'b0, 64'h0, 1'b0);
        head(enc_opr(5'd1, 5'd2, 5'd10), 64'h500, 1'b0, e);
        cycle(); chk_bit("t5_pal_wait", acc_s, 1'b0);
        cycle(); chk_bit("t5_pal_wait2", acc_s, 1'b0);
        redir_vld = 1'b1;
        cycle(); chk_bit("t5_redir_acc", acc_s, 1'b0);
        redir_vld = 1'b0;
        cycle(); chk_bit("t5_after_redir_acc", acc_s, 1'b1);
        idle(); cycle();
        wb_clear(5'd10);

        // Decode formats, issued back to back
        e = mk(64'h600, enc_br(6'h30, 5'd26, 21'h1F_FFFF), BR, 5'd31, 5'd31, 5'd26, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        head(enc_br(6'h30, 5'd26, 21'h1F_FFFF), 64'h600, 1'b1, e);
        cycle(); chk_bit("d_br_acc", acc_s, 1'b1);
        e = mk(64'h604, enc_br(6'h39, 5'd3, 21'd5), CBR, 5'd3, 5'd31, 5'd31, 1'b0, 64'h14, 1'b0);
        head(enc_br(6'h39, 5'd3, 21'd5), 64'h604, 1'b0, e);
        cycle(); chk_bit("d_cbr_acc", acc_s, 1'b1);
        e = mk(64'h608, enc_mem(6'h2D, 5'd5, 5'd6, 16'h0008), MEM_ST, 5'd5, 5'd6, 5'd31, 1'b0, 64'h8, 1'b0);
        head(enc_mem(6'h2D, 5'd5, 5'd6, 16'h0008), 64'h608, 1'b0, e);
        cycle(); chk_bit("d_st_acc", acc_s, 1'b1);
        e = mk(64'h60C, enc_lit(5'd1, 8'h7F, 5'd2), OPR, 5'd1, 5'd31, 5'd2, 1'b1, 64'h7F, 1'b0);
        head(enc_lit(5'd1, 8'h7F, 5'd2), 64'h60C, 1'b0, e);
        cycle(); chk_bit("d_lit_acc", acc_s, 1'b1);
        e = mk(64'h610, 32'h0400_0000, OPR, 5'd31, 5'd31, 5'd31, 1'b0, 64'h0, 1'b0);
        head(32'h0400_0000, 64'h610, 1'b0, e);
        cycle(); chk_bit("d_ill_nop_acc", acc_s, 1'b1);
        idle(); cycle();
        wb_clear(5'd26); wb_clear(5'd2);

        // Redirect flushes ex but keeps the scoreboard
        e = mk(64'h700, enc_mem(6'h29, 5'd4, 5'd3, 16'h0000), MEM_LD, 5'd31, 5'd3, 5'd4, 1'b0, 64'h0, 1'b0);
        head(enc_mem(6'h29, 5'd4, 5'd3, 16'h0000), 64'h700, 1'b0, e);
        cycle(); chk_bit("t6_ld4_acc", acc_s, 1'b1);
        e = mk(64'h704, enc_opr(5'd1, 5'd2, 5'd6), OPR, 5'd1, 5'd2, 5'd6, 1'b0, 64'h0, 1'b0);
        head(enc_opr(5'd1, 5'd2, 5'd6), 64'h704, 1'b0, e);
        cycle(); chk_bit("t6_add_acc", acc_s, 1'b1);
        ex_ready = 1'b0; redir_vld = 1'b1;
        e = mk(64'h800, enc_opr(5'd4, 5'd2, 5'd8), OPR, 5'd4, 5'd2, 5'd8, 1'b0, 64'h0, 1'b0);
        head(enc_opr(5'd4, 5'd2, 5'd8), 64'h800, 1'b0, e);
        cycle(); chk_bit("t6_redir_acc", acc_s, 1'b0);
        chk_bit("t6_redir_vld_pre", exv_s, 1'b1);
        redir_vld = 1'b0; ex_ready = 1'b1;
        chk_bit("t6_flush_vld", ex_vld, 1'b0);
        cycle(); chk_bit("t6_sb_kept", acc_s, 1'b0);
        wb_vld = 1'b1; wb_reg = 5'd4;
        cycle(); chk_bit("t6_wb_accept", acc_s, 1'b1);
        wb_vld = 1'b0; idle(); cycle();
        cycle();

        chk_int("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
